// File: rtl/riscv_dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// Request and response channels each use a valid/ready handshake.
interface riscv_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Multi-cycle data-memory slave: one request at a time, LATENCY wait cycles,
// one access cycle, then a held response until the core accepts it.
module riscv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_wen;
  logic [3:0]  lat_wstrb;
  logic [31:0] rdata;
  logic        err;
  logic        addr_err;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    addr_err = (lat_addr[1:0] != 2'b00) || ({2'b00, lat_addr[31:2]} >= DEPTH_WORDS);
    idx      = lat_addr[IDX_W+1:2];
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_addr  <= bus.req_addr;
            lat_wen   <= bus.req_wen;
            lat_wdata <= bus.req_wdata;
            lat_wstrb <= bus.req_wstrb;
            cnt       <= 4'(LATENCY);
            state     <= (LATENCY > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          err   <= addr_err;
          rdata <= (addr_err || lat_wen) ? '0 : mem[idx];
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && lat_wen && !addr_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_wstrb[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: LATENCY=2 instance for most scenarios,
// LATENCY=0 instance for back-to-back throughput and ordering.
module tb_riscv_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_dmem_responder_if bus2 ();
  riscv_dmem_responder_if bus0 ();

  riscv_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );
  riscv_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  // One complete transaction on the LATENCY=2 instance; lat = -1 on timeout.
  task automatic req2(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                      output int lat);
    int h;
    int t;
    lat = -1; rdata = 'x; err = 1'bx;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_addr = addr; bus2.req_wen = wen;
    bus2.req_wdata = wdata; bus2.req_wstrb = wstrb;
    t = 0;
    while (!bus2.req_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus2.req_ready) begin bus2.req_valid = 1'b0; return; end
    h = cyc;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0; bus2.req_addr = '1; bus2.req_wdata = '1; bus2.req_wstrb = '1;
    @(negedge clk);
    t = 0;
    while (!bus2.rsp_valid && t < 40) begin @(negedge clk); t++; end
    if (bus2.rsp_valid) begin
      lat = cyc - h; rdata = bus2.rsp_rdata; err = bus2.rsp_err;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.req_wen = 1'b0;
    bus2.req_wdata = '0; bus2.req_wstrb = '0; bus2.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_wen = 1'b0;
    bus0.req_wdata = '0; bus0.req_wstrb = '0; bus0.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    total++; if (bus2.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus2.req_ready); else passed++;
    total++; if (bus2.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus2.rsp_valid); else passed++;
    total++; if (bus2.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 00000000", bus2.rsp_rdata); else passed++;
    total++; if (bus2.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus2.rsp_err); else passed++;
    total++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) $display("FAIL reset_lat0_hs: got ready=%b valid=%b expected ready=1 valid=0", bus0.req_ready, bus0.rsp_valid); else passed++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat;
    req2(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, e, lat);
    total++; if (lat !== 4) $display("FAIL wr_latency: got %0d expected 4", lat); else passed++;
    total++; if (rd !== 32'h0 || e !== 1'b0) $display("FAIL wr_rsp: got rdata=%h err=%b expected rdata=00000000 err=0", rd, e); else passed++;
    req2(32'h10, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (lat !== 4) $display("FAIL rd_latency: got %0d expected 4", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rd); else passed++;
    total++; if (e !== 1'b0) $display("FAIL rd_err: got %b expected 0", e); else passed++;
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic e; int lat;
    req2(32'h20, 1'b1, 32'h11223344, 4'hF, rd, e, lat);
    req2(32'h20, 1'b1, 32'h0000AA00, 4'b0010, rd, e, lat);
    req2(32'h20, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h1122AA44) $display("FAIL strobe_merge: got %h expected 1122aa44", rd); else passed++;
    req2(32'h20, 1'b1, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
    total++; if (e !== 1'b0 || lat !== 4) $display("FAIL strobe_zero_rsp: got err=%b lat=%0d expected err=0 lat=4", e, lat); else passed++;
    req2(32'h20, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h1122AA44) $display("FAIL strobe_zero_noop: got %h expected 1122aa44", rd); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    req2(32'h0, 1'b1, 32'h0BADF00D, 4'hF, rd, e, lat);
    req2(32'h22, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_rd: got err=%b rdata=%h expected err=1 rdata=00000000", e, rd); else passed++;
    req2(32'h1000, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL oor_rd: got err=%b rdata=%h expected err=1 rdata=00000000", e, rd); else passed++;
    req2(32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL oor_wr: got err=%b rdata=%h expected err=1 rdata=00000000", e, rd); else passed++;
    req2(32'h2, 1'b1, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL misaligned_wr: got err=%b expected 1", e); else passed++;
    req2(32'h0, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h0BADF00D || e !== 1'b0) $display("FAIL word0_intact: got rdata=%h err=%b expected rdata=0badf00d err=0", rd, e); else passed++;
  endtask

  task automatic test_rsp_hold();
    logic [31:0] cap_d; logic cap_e; int t;
    bus2.rsp_ready = 1'b0;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h10; bus2.req_wen = 1'b0; bus2.req_wstrb = 4'h0;
    t = 0;
    while (!bus2.req_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    @(negedge clk);
    t = 0;
    while (!bus2.rsp_valid && t < 40) begin @(negedge clk); t++; end
    cap_d = bus2.rsp_rdata; cap_e = bus2.rsp_err;
    total++; if (cap_d !== 32'hDEADBEEF || cap_e !== 1'b0) $display("FAIL hold_first: got rdata=%h err=%b expected rdata=deadbeef err=0", cap_d, cap_e); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus2.rsp_valid !== 1'b1 || bus2.rsp_rdata !== cap_d || bus2.rsp_err !== cap_e || bus2.req_ready !== 1'b0)
        $display("FAIL hold_stable: got valid=%b rdata=%h err=%b ready=%b expected valid=1 rdata=%h err=%b ready=0",
                 bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err, bus2.req_ready, cap_d, cap_e);
      else passed++;
    end
    bus2.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0) $display("FAIL hold_release: got ready=%b valid=%b expected ready=1 valid=0", bus2.req_ready, bus2.rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic e; int lat; int seen;
    req2(32'h40, 1'b1, 32'h12345678, 4'hF, rd, e, lat);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h40; bus2.req_wen = 1'b1;
    bus2.req_wdata = 32'hCAFEF00D; bus2.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus2.req_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", bus2.req_ready); else passed++;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus2.rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL midrst_no_rsp: got %0d response cycles expected 0", seen); else passed++;
    req2(32'h40, 1'b0, 32'h0, 4'h0, rd, e, lat);
    total++; if (rd !== 32'h12345678 || e !== 1'b0) $display("FAIL midrst_preserve: got rdata=%h err=%b expected rdata=12345678 err=0", rd, e); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[6]      = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h0, 32'h8};
    logic        w[6]      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] d[6]      = '{32'hA5A5A5A5, 32'h01020304, 32'hFFEEDDCC, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_rd[6] = '{32'h0, 32'h0, 32'h0, 32'h01020304, 32'hA5A5A5A5, 32'hFFEEDDCC};
    int          rc[6];
    logic [31:0] rd[6];
    logic        re[6];
    int          hs0 = -1000;
    int          n = 0;
    bus0.rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int t;
          @(negedge clk);
          bus0.req_valid = 1'b1; bus0.req_addr = a[i]; bus0.req_wen = w[i];
          bus0.req_wdata = d[i]; bus0.req_wstrb = 4'hF;
          t = 0;
          while (!bus0.req_ready && t < 20) begin @(negedge clk); t++; end
          if (i == 0) hs0 = cyc;
          @(posedge clk);
        end
        @(negedge clk);
        bus0.req_valid = 1'b0;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (bus0.rsp_valid === 1'b1 && n < 6) begin
            rc[n] = cyc; rd[n] = bus0.rsp_rdata; re[n] = bus0.rsp_err; n++;
          end
        end
      end
    join
    total++; if (n !== 6) $display("FAIL b2b_count: got %0d responses expected 6", n); else passed++;
    for (int j = 0; j < n; j++) begin
      total++; if (rc[j] - hs0 !== 2 + 3*j) $display("FAIL b2b_timing[%0d]: got cycle %0d expected %0d", j, rc[j] - hs0, 2 + 3*j); else passed++;
      total++; if (rd[j] !== exp_rd[j] || re[j] !== 1'b0) $display("FAIL b2b_data[%0d]: got rdata=%h err=%b expected rdata=%h err=0", j, rd[j], re[j], exp_rd[j]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_errors();
    test_rsp_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
